// File: rtl/x86_core_pkg.sv
// Shared x86 core types: register file geometry, writeback request payload,
// writeback FSM states and architectural register indices.
package x86_core_pkg;

  localparam int unsigned REG_ADDR_W = 3;
  localparam int unsigned REG_DATA_W = 8;
  localparam int unsigned NUM_REGS   = 1 << REG_ADDR_W;

  localparam logic [REG_ADDR_W-1:0] AX = 3'd0;
  localparam logic [REG_ADDR_W-1:0] BX = 3'd1;
  localparam logic [REG_ADDR_W-1:0] CX = 3'd2;
  localparam logic [REG_ADDR_W-1:0] DX = 3'd3;
  localparam logic [REG_ADDR_W-1:0] SI = 3'd4;
  localparam logic [REG_ADDR_W-1:0] DI = 3'd5;
  localparam logic [REG_ADDR_W-1:0] BP = 3'd6;
  localparam logic [REG_ADDR_W-1:0] SP = 3'd7;

  typedef struct packed {
    logic [REG_ADDR_W-1:0]   addr;
    logic [2*REG_DATA_W-1:0] data;
    logic                    wide;
  } wb_req_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    NARROW  = 2'd1,
    WIDE_LO = 2'd2,
    WIDE_HI = 2'd3
  } wb_state_e;

  // High half of a wide write goes to the next register, wrapping at the top.
  function automatic logic [REG_ADDR_W-1:0] next_reg(input logic [REG_ADDR_W-1:0] a);
    return a + REG_ADDR_W'(1);
  endfunction

endpackage

// File: rtl/wb_sync_fifo.sv
// Synchronous FIFO of writeback requests; also exposes every slot and its
// valid bit so the owner can decode which registers have queued writes.
module wb_sync_fifo
  import x86_core_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  wb_req_t                  push_data,
  output wb_req_t                  head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic [DEPTH-1:0]         entry_valid,
  output wb_req_t [DEPTH-1:0]      entries
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned PTR_W = IDX_W + 1;

  logic [PTR_W-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
  wb_req_t [DEPTH-1:0] mem_q, mem_d;
  logic                do_push, do_pop;
  logic [IDX_W-1:0]    offset;

  // A push on a full FIFO is refused even if a pop happens the same cycle.
  always_comb begin
    count   = wptr_q - rptr_q;
    full    = (count == PTR_W'(DEPTH));
    empty   = (wptr_q == rptr_q);
    do_push = push && !full;
    do_pop  = pop && !empty;
    wptr_d  = wptr_q + PTR_W'(do_push);
    rptr_d  = rptr_q + PTR_W'(do_pop);
    mem_d   = mem_q;
    if (do_push) mem_d[wptr_q[IDX_W-1:0]] = push_data;
    head    = mem_q[rptr_q[IDX_W-1:0]];
    entries = mem_q;
    offset  = '0;
    entry_valid = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      offset         = IDX_W'(i) - rptr_q[IDX_W-1:0];
      entry_valid[i] = (PTR_W'(offset) < count);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/x86_reg_writeback_ctrl.sv
// Writeback controller: queues execute/load results and drains them one byte
// per cycle onto the register file write port, splitting wide results in two.
module x86_reg_writeback_ctrl
  import x86_core_pkg::*;
#(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = REG_ADDR_W,
  parameter int unsigned DATA_W = REG_DATA_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wb_valid,
  output logic                 wb_ready,
  input  logic [ADDR_W-1:0]    wb_addr,
  input  logic [2*DATA_W-1:0]  wb_data,
  input  logic                 wb_wide,
  output logic [ADDR_W-1:0]    write_addr,
  output logic [DATA_W-1:0]    write_data,
  output logic                 write_enable,
  output logic [(1<<ADDR_W)-1:0] pending_mask,
  output logic                 busy
);

  wb_req_t             push_req, head;
  wb_req_t [DEPTH-1:0] ents;
  logic [DEPTH-1:0]    ent_v;
  logic                fifo_full, fifo_empty, pop;
  logic [$clog2(DEPTH):0] fifo_count;

  wb_state_e         state_q, state_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d, hi_addr_q, hi_addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d, hi_data_q, hi_data_d;

  assign push_req = '{addr: wb_addr, data: wb_data, wide: wb_wide};

  wb_sync_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (wb_valid),
    .pop        (pop),
    .push_data  (push_req),
    .head       (head),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .count      (fifo_count),
    .entry_valid(ent_v),
    .entries    (ents)
  );

  // NARROW and WIDE_HI mean "last byte of a request is on the port", so they
  // share IDLE's pop logic and chain back-to-back without a bubble.
  always_comb begin
    state_d   = state_q;
    we_d      = 1'b0;
    waddr_d   = waddr_q;
    wdata_d   = wdata_q;
    hi_addr_d = hi_addr_q;
    hi_data_d = hi_data_q;
    pop       = 1'b0;
    if (state_q == WIDE_LO) begin
      we_d    = 1'b1;
      waddr_d = hi_addr_q;
      wdata_d = hi_data_q;
      state_d = WIDE_HI;
    end else if (!fifo_empty) begin
      pop       = 1'b1;
      we_d      = 1'b1;
      waddr_d   = head.addr;
      wdata_d   = head.data[DATA_W-1:0];
      hi_addr_d = next_reg(head.addr);
      hi_data_d = head.data[2*DATA_W-1:DATA_W];
      state_d   = head.wide ? WIDE_LO : NARROW;
    end else begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      we_q      <= 1'b0;
      waddr_q   <= '0;
      wdata_q   <= '0;
      hi_addr_q <= '0;
      hi_data_q <= '0;
    end else begin
      state_q   <= state_d;
      we_q      <= we_d;
      waddr_q   <= waddr_d;
      wdata_q   <= wdata_d;
      hi_addr_q <= hi_addr_d;
      hi_data_q <= hi_data_d;
    end
  end

  // Registers still owed a write: queued entries, the port, and a pending hi byte.
  always_comb begin
    pending_mask = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (ent_v[i]) begin
        pending_mask[ents[i].addr] = 1'b1;
        if (ents[i].wide) pending_mask[next_reg(ents[i].addr)] = 1'b1;
      end
    end
    if (we_q) pending_mask[waddr_q] = 1'b1;
    if (state_q == WIDE_LO) pending_mask[hi_addr_q] = 1'b1;
  end

  assign wb_ready     = !fifo_full;
  assign busy         = (fifo_count != '0) || (state_q != IDLE);
  assign write_enable = we_q;
  assign write_addr   = waddr_q;
  assign write_data   = wdata_q;

endmodule

// File: tb/tb_x86_reg_writeback_ctrl.sv
// Directed bench: writeback controller driving a behavioural register file.
module tb_x86_reg_writeback_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_valid, wb_ready, wb_wide;
  logic [2:0]  wb_addr;
  logic [15:0] wb_data;
  logic [2:0]  write_addr;
  logic [7:0]  write_data;
  logic        write_enable;
  logic [7:0]  pending_mask;
  logic        busy;

  int checks = 0;
  int errors = 0;

  logic [7:0]  rf [8];
  logic [10:0] wlog [$];

  x86_reg_writeback_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .wb_valid    (wb_valid),
    .wb_ready    (wb_ready),
    .wb_addr     (wb_addr),
    .wb_data     (wb_data),
    .wb_wide     (wb_wide),
    .write_addr  (write_addr),
    .write_data  (write_data),
    .write_enable(write_enable),
    .pending_mask(pending_mask),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  // Register file behind the write port, plus a log of every write.
  always @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < 8; r++) rf[r] <= 8'h00;
    end else if (write_enable) begin
      rf[write_addr] <= write_data;
    end
    if (write_enable) wlog.push_back({write_addr, write_data});
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_port(input string tag, input logic we, input logic [2:0] a, input logic [7:0] d);
    check({tag, "_we"}, 32'(write_enable), 32'(we));
    if (we) begin
      check({tag, "_addr"}, 32'(write_addr), 32'(a));
      check({tag, "_data"}, 32'(write_data), 32'(d));
    end
  endtask

  logic [2:0]  bp_addr [8];
  logic [15:0] bp_data [8];
  logic [10:0] exp_log [$];
  int          base, waited, accepted_before_stall;
  bit          stalled;

  initial begin
    rst = 1'b1; wb_valid = 1'b0; wb_addr = '0; wb_data = '0; wb_wide = 1'b0;

    // Reset
    tick(); tick();
    check("rst_we", 32'(write_enable), 32'd0);
    check("rst_mask", 32'(pending_mask), 32'h00);
    check("rst_ready", 32'(wb_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;

    // Single narrow write to AX
    wb_valid = 1'b1; wb_addr = 3'd0; wb_data = 16'h0001; wb_wide = 1'b0;
    tick();
    wb_valid = 1'b0;
    check_port("nar_n", 1'b0, 3'd0, 8'h00);
    check("nar_mask_q", 32'(pending_mask), 32'h01);
    check("nar_busy", 32'(busy), 32'd1);
    tick();
    check_port("nar_n1", 1'b1, 3'd0, 8'h01);
    check("nar_mask_p", 32'(pending_mask), 32'h01);
    tick();
    check_port("nar_n2", 1'b0, 3'd0, 8'h00);
    check("nar_mask_clr", 32'(pending_mask), 32'h00);
    check("nar_ax", 32'(rf[0]), 32'h01);

    // Burst of three narrow writes, no bubbles
    wb_valid = 1'b1; wb_addr = 3'd0; wb_data = 16'h0001; tick();
    wb_addr = 3'd1; wb_data = 16'h0004; tick();
    check_port("bur_ax", 1'b1, 3'd0, 8'h01);
    wb_addr = 3'd2; wb_data = 16'h0005; tick();
    wb_valid = 1'b0;
    check_port("bur_bx", 1'b1, 3'd1, 8'h04);
    check("bur_mask", 32'(pending_mask), 32'h06);
    tick();
    check_port("bur_cx", 1'b1, 3'd2, 8'h05);
    tick();
    check_port("bur_end", 1'b0, 3'd0, 8'h00);
    check("bur_rf_ax", 32'(rf[0]), 32'h01);
    check("bur_rf_bx", 32'(rf[1]), 32'h04);
    check("bur_rf_cx", 32'(rf[2]), 32'h05);

    // Wide write at SP wraps into AX
    wb_valid = 1'b1; wb_addr = 3'd7; wb_data = 16'hBEEF; wb_wide = 1'b1;
    tick();
    wb_valid = 1'b0;
    check("wide_mask_q", 32'(pending_mask), 32'h81);
    tick();
    check_port("wide_lo", 1'b1, 3'd7, 8'hEF);
    check("wide_mask_lo", 32'(pending_mask), 32'h81);
    tick();
    check_port("wide_hi", 1'b1, 3'd0, 8'hBE);
    check("wide_mask_hi", 32'(pending_mask), 32'h01);
    tick();
    check_port("wide_end", 1'b0, 3'd0, 8'h00);
    check("wide_mask_clr", 32'(pending_mask), 32'h00);
    check("wide_rf_sp", 32'(rf[7]), 32'hEF);
    check("wide_rf_ax", 32'(rf[0]), 32'hBE);

    // Backpressure: eight wide requests outrun the two-cycle drain
    bp_addr = '{3'd1, 3'd3, 3'd5, 3'd7, 3'd2, 3'd4, 3'd6, 3'd0};
    bp_data = '{16'h1122, 16'h3344, 16'h5566, 16'h7788, 16'h99AA, 16'hBBCC, 16'hDDEE, 16'hF00F};
    exp_log.delete();
    for (int k = 0; k < 8; k++) begin
      exp_log.push_back({bp_addr[k], bp_data[k][7:0]});
      exp_log.push_back({bp_addr[k] + 3'd1, bp_data[k][15:8]});
    end
    base = wlog.size();
    stalled = 1'b0; accepted_before_stall = -1;
    for (int k = 0; k < 8; k++) begin
      wb_valid = 1'b1; wb_addr = bp_addr[k]; wb_data = bp_data[k]; wb_wide = 1'b1;
      waited = 0;
      while (!wb_ready && waited < 50) begin
        if (!stalled) begin stalled = 1'b1; accepted_before_stall = k; end
        tick(); waited++;
      end
      check("bp_ready_timeout", 32'(wb_ready), 32'd1);
      tick();
    end
    wb_valid = 1'b0; wb_wide = 1'b0;
    check("bp_stalled", 32'(stalled), 32'd1);
    check("bp_stall_point", 32'(accepted_before_stall), 32'd7);
    waited = 0;
    while (busy && waited < 100) begin tick(); waited++; end
    check("bp_drain_timeout", 32'(busy), 32'd0);
    check("bp_log_len", 32'(wlog.size() - base), 32'd16);
    for (int k = 0; k < 16; k++) begin
      if (base + k < wlog.size())
        check($sformatf("bp_log%0d", k), 32'(wlog[base + k]), 32'(exp_log[k]));
    end
    check("bp_mask_clr", 32'(pending_mask), 32'h00);

    // Reset during WIDE_LO discards the hi byte and the queued narrow write
    base = wlog.size();
    wb_valid = 1'b1; wb_addr = 3'd5; wb_data = 16'h1234; wb_wide = 1'b1; tick();
    wb_addr = 3'd3; wb_data = 16'h0099; wb_wide = 1'b0; tick();
    wb_valid = 1'b0;
    check_port("rw_lo", 1'b1, 3'd5, 8'h34);
    check("rw_mask_lo", 32'(pending_mask), 32'h68);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rw_we", 32'(write_enable), 32'd0);
    check("rw_mask", 32'(pending_mask), 32'h00);
    check("rw_busy", 32'(busy), 32'd0);
    check("rw_ready", 32'(wb_ready), 32'd1);
    for (int k = 0; k < 6; k++) tick();
    check("rw_log_len", 32'(wlog.size() - base), 32'd1);
    check("rw_busy_late", 32'(busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
